// File: rtl/store_unit.sv
// Store unit: formats RISC-V stores and queues them for the data BRAM.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned sh/sw instead of aligning them.
module store_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_func3,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_dat,
  output logic [3:0]        w_be,
  output logic              w_enb,
  input  logic              w_rdy,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              st_err,
  output logic [3:0]        pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       dat;
    logic [3:0]        be;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              legal;
  logic [31:0]       fmt_dat;
  logic [3:0]        fmt_be;
  logic              accept, push, pop;
  logic              unused_bits;

  assign unused_bits = ^{st_addr[31:ADDR_W], st_addr[1:0], ld_addr[1:0]};

  always_comb begin
    legal   = 1'b1;
    fmt_dat = st_data;
    fmt_be  = 4'b1111;
    case (st_func3)
      3'b000: begin
        fmt_dat = {4{st_data[7:0]}};
        fmt_be  = 4'b0001 << st_addr[1:0];
      end
      3'b001: begin
        fmt_dat = {2{st_data[15:0]}};
        fmt_be  = st_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
        if (st_addr[0]) legal = 1'b0;
`endif
      end
      3'b010: begin
`ifdef STORE_MISALIGN_TRAP_EN
        if (st_addr[1:0] != 2'b00) legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

  // Full means no accept, even if the head retires this same cycle.
  assign st_ready = (cnt_q < 4'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && legal;
  assign w_enb    = (cnt_q != 4'd0);
  assign pop      = w_enb && w_rdy;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    err_d = accept && !legal;
    if (push) begin
      wr_d        = wr_q + PW'(1);
      vld_d[wr_q] = 1'b1;
    end
    if (pop) begin
      rd_d        = rd_q + PW'(1);
      vld_d[rd_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      err_q <= err_d;
      if (push) begin
        mem_q[wr_q].addr <= {st_addr[ADDR_W-1:2], 2'b00};
        mem_q[wr_q].dat  <= fmt_dat;
        mem_q[wr_q].be   <= fmt_be;
      end
    end
  end

  assign w_addr  = w_enb ? mem_q[rd_q].addr : '0;
  assign w_dat   = w_enb ? mem_q[rd_q].dat  : '0;
  assign w_be    = w_enb ? mem_q[rd_q].be   : '0;
  assign st_err  = err_q;
  assign pending = cnt_q;

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: formatting table plus backpressure,
// hazard and reset sequences.
module tb_store_unit;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_func3;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_dat;
  logic [3:0]        w_be;
  logic              w_enb;
  logic              w_rdy;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
  logic              st_err;
  logic [3:0]        pending;

  int checks = 0;
  int errors = 0;

  store_unit #(.DEPTH(2), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_func3  (st_func3),
    .w_addr    (w_addr),
    .w_dat     (w_dat),
    .w_be      (w_be),
    .w_enb     (w_enb),
    .w_rdy     (w_rdy),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .st_err    (st_err),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] e_addr;
    logic [31:0] e_dat;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    st_valid = 1'b1;
    st_func3 = f3;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    vecs[0] = '{"sw_008", 3'b010, 32'h008, 32'hDEADBEEF, 1'b0,
                32'h008, 32'hDEADBEEF, 4'b1111};
    vecs[1] = '{"sb_00E", 3'b000, 32'h00E, 32'h000000A5, 1'b0,
                32'h00C, 32'hA5A5A5A5, 4'b0100};
    vecs[2] = '{"sh_006", 3'b001, 32'h006, 32'h00001234, 1'b0,
                32'h004, 32'h12341234, 4'b1100};
    vecs[3] = '{"sb_001", 3'b000, 32'h001, 32'h7777773C, 1'b0,
                32'h000, 32'h3C3C3C3C, 4'b0010};
    vecs[4] = '{"sh_010", 3'b001, 32'h010, 32'hABCDBEEF, 1'b0,
                32'h010, 32'hBEEFBEEF, 4'b0011};
    vecs[5] = '{"f3_011", 3'b011, 32'h020, 32'h11111111, 1'b1,
                32'h0, 32'h0, 4'b0};
    vecs[6] = '{"f3_100", 3'b100, 32'h024, 32'h22222222, 1'b1,
                32'h0, 32'h0, 4'b0};
`ifdef STORE_MISALIGN_TRAP_EN
    vecs[7] = '{"sw_002", 3'b010, 32'h002, 32'h11223344, 1'b1,
                32'h0, 32'h0, 4'b0};
    vecs[8] = '{"sh_003", 3'b001, 32'h003, 32'h0000CAFE, 1'b1,
                32'h0, 32'h0, 4'b0};
`else
    vecs[7] = '{"sw_002", 3'b010, 32'h002, 32'h11223344, 1'b0,
                32'h000, 32'h11223344, 4'b1111};
    vecs[8] = '{"sh_003", 3'b001, 32'h003, 32'h0000CAFE, 1'b0,
                32'h000, 32'hCAFECAFE, 4'b1100};
`endif
    vecs[9] = '{"sw_hi", 3'b010, 32'hFFFFF3FC, 32'h5A5A0F0F, 1'b0,
                32'h3FC, 32'h5A5A0F0F, 4'b1111};

    rst = 1'b0;
    st_valid = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_func3 = '0;
    w_rdy = 1'b1;
    ld_addr = '0;
    tick();
    tick();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_wenb", 32'(w_enb), 32'd0);
    chk("rst_wbe", 32'(w_be), 32'd0);
    chk("rst_wdat", w_dat, 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'd0);
    chk("rst_err", 32'(st_err), 32'd0);
    chk("rst_haz", 32'(ld_hazard), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].f3, vecs[i].addr, vecs[i].data);
      tick();
      st_valid = 1'b0;
      chk({vecs[i].name, "_err"}, 32'(st_err), 32'(vecs[i].err));
      if (vecs[i].err) begin
        chk({vecs[i].name, "_pend"}, 32'(pending), 32'd0);
        chk({vecs[i].name, "_wenb"}, 32'(w_enb), 32'd0);
      end else begin
        chk({vecs[i].name, "_wenb"}, 32'(w_enb), 32'd1);
        chk({vecs[i].name, "_addr"}, 32'(w_addr), vecs[i].e_addr);
        chk({vecs[i].name, "_dat"}, w_dat, vecs[i].e_dat);
        chk({vecs[i].name, "_be"}, 32'(w_be), 32'(vecs[i].e_be));
      end
      tick();
      chk({vecs[i].name, "_drain"}, 32'(pending), 32'd0);
      chk({vecs[i].name, "_errclr"}, 32'(st_err), 32'd0);
    end

    // backpressure: three back-to-back sw into a 2-entry buffer
    w_rdy = 1'b0;
    drive(3'b010, 32'h020, 32'h1);
    tick();
    chk("bp_pend1", 32'(pending), 32'd1);
    chk("bp_rdy1", 32'(st_ready), 32'd1);
    drive(3'b010, 32'h024, 32'h2);
    tick();
    chk("bp_pend2", 32'(pending), 32'd2);
    chk("bp_rdy2", 32'(st_ready), 32'd0);
    drive(3'b010, 32'h028, 32'h3);
    tick();
    chk("bp_full_pend", 32'(pending), 32'd2);
    chk("bp_head_addr", 32'(w_addr), 32'h020);
    chk("bp_head_dat", w_dat, 32'h1);
    chk("bp_wenb", 32'(w_enb), 32'd1);
    ld_addr = 10'h026;
    #1;
    chk("haz_second", 32'(ld_hazard), 32'd1);
    ld_addr = 10'h02C;
    #1;
    chk("haz_none", 32'(ld_hazard), 32'd0);
    w_rdy = 1'b1;
    tick();
    chk("bp_pop1_pend", 32'(pending), 32'd1);
    chk("bp_pop1_addr", 32'(w_addr), 32'h024);
    chk("bp_pop1_dat", w_dat, 32'h2);
    tick();
    chk("bp_pop2_pend", 32'(pending), 32'd1);
    chk("bp_pop2_addr", 32'(w_addr), 32'h028);
    chk("bp_pop2_dat", w_dat, 32'h3);
    st_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(pending), 32'd0);
    chk("bp_empty_wenb", 32'(w_enb), 32'd0);
    chk("bp_empty_be", 32'(w_be), 32'd0);

    // load hazard against a stalled store, then reset mid-operation
    w_rdy = 1'b0;
    drive(3'b010, 32'h010, 32'hCAFEF00D);
    tick();
    drive(3'b000, 32'h031, 32'h55);
    tick();
    st_valid = 1'b0;
    chk("haz_pend2", 32'(pending), 32'd2);
    ld_addr = 10'h012;
    #1;
    chk("haz_012", 32'(ld_hazard), 32'd1);
    ld_addr = 10'h014;
    #1;
    chk("haz_014", 32'(ld_hazard), 32'd0);
    ld_addr = 10'h033;
    #1;
    chk("haz_033", 32'(ld_hazard), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_pend", 32'(pending), 32'd0);
    chk("mrst_wenb", 32'(w_enb), 32'd0);
    chk("mrst_ready", 32'(st_ready), 32'd1);
    chk("mrst_haz", 32'(ld_hazard), 32'd0);
    w_rdy = 1'b1;
    tick();
    chk("mrst_stay", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of write-buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning data BRAM byte-address width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port st_valid  input  1  store request from execute stage.
REQ-006 SHALL have port st_ready  output  1  buffer can accept a store.
REQ-007 SHALL have port st_addr  input  32  byte address (ALU result).
REQ-008 SHALL have port st_data  input  32  rs2 value.
REQ-009 SHALL have port st_func3  input  3  store width: 000 sb, 001 sh, 010 sw.
REQ-010 SHALL have port w_addr  output  ADDR_W  word-aligned byte address to data BRAM (bits [1:0] = 0).
REQ-011 SHALL have port w_dat  output  32  lane-aligned write data.
REQ-012 SHALL have port w_be  output  4  byte enables, bit n = byte lane n.
REQ-013 SHALL have port w_enb  output  1  write strobe to data BRAM.
REQ-014 SHALL have port w_rdy  input  1  data BRAM accepts the write this cycle.
REQ-015 SHALL have port ld_addr  input  ADDR_W  pending load byte address.
REQ-016 SHALL have port ld_hazard  output  1  a buffered store targets ld_addr's word.
REQ-017 SHALL have port st_err  output  1  one-cycle pulse: rejected store.
REQ-018 SHALL have port pending  output  4  number of valid buffer entries.

Function
REQ-019 SHALL accept a store when st_valid && st_ready; st_ready = (pending < DEPTH); no pass-through when full, even if a write retires in the same cycle.
REQ-020 SHALL format at accept: sb -> w_dat = {4{st_data[7:0]}}, w_be = 0001 << st_addr[1:0]; sh -> w_dat = {2{st_data[15:0]}}, w_be = 0011 or 1100 by st_addr[1]; sw -> w_dat = st_data, w_be = 1111.
REQ-021 SHALL store w_addr = {st_addr[ADDR_W-1:2], 2'b00}; st_addr bits above ADDR_W are ignored.
REQ-022 SHALL treat func3 outside {000,001,010} as illegal: not enqueued, st_err pulses the cycle after the accept handshake.
REQ-023 SHALL present the FIFO head on w_addr/w_dat/w_be with w_enb = (pending != 0), all driven from registers; minimum accept-to-w_enb latency 1 cycle.
REQ-024 SHALL pop the head when w_enb && w_rdy; w_addr/w_dat/w_be hold stable while w_enb && !w_rdy.
REQ-025 SHALL retire stores strictly in acceptance order; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL push and pop in the same cycle when not full, leaving pending unchanged.
REQ-027 SHALL drive ld_hazard combinationally = OR over valid entries of (entry word address == ld_addr[ADDR_W-1:2]); 0 when empty.
REQ-028 SHALL drive w_dat = 0 and w_be = 0 when pending = 0.

Reset
REQ-029 SHALL on rst = 0 at a rising edge clear all entries and pointers: pending = 0, w_enb = 0, w_be = 0, w_dat = 0, w_addr = 0, st_err = 0, ld_hazard = 0, st_ready = 1.
REQ-030 SHALL discard buffered stores on reset mid-operation; no BRAM write is issued in the reset cycle.

Configuration
REQ-031 SHALL, with STORE_MISALIGN_TRAP_EN defined, treat sh with st_addr[0] = 1 and sw with st_addr[1:0] != 0 as illegal, handled as in REQ-022.
REQ-032 SHALL, without STORE_MISALIGN_TRAP_EN, force alignment by ignoring st_addr[0] for sh and st_addr[1:0] for sw, never flagging misalignment.

Verification
REQ-033 SHALL cover: sw addr 0x008 data 0xDEADBEEF, w_rdy = 1 -> next cycle w_enb = 1, w_addr = 0x008, w_be = 1111, w_dat = 0xDEADBEEF, then pending = 0.
REQ-034 SHALL cover: sb addr 0x00E data 0x000000A5 -> w_addr = 0x00C, w_be = 0100, w_dat = 0xA5A5A5A5; sh addr 0x006 data 0x1234 -> w_be = 1100, w_dat = 0x12341234.
REQ-035 SHALL cover: w_rdy = 0, three back-to-back sw (DEPTH = 2) -> st_ready = 0 after two accepts, head stable; w_rdy = 1 -> writes retire in order, third accepted.
REQ-036 SHALL cover: sw to 0x010 buffered with w_rdy = 0, ld_addr = 0x012 -> ld_hazard = 1; ld_addr = 0x014 -> ld_hazard = 0.
REQ-037 SHALL cover: func3 = 011 -> st_err pulse, pending unchanged; with STORE_MISALIGN_TRAP_EN, sw addr 0x002 -> st_err; without it -> write to 0x000, w_be = 1111.
REQ-038 SHALL cover: rst = 0 with two entries pending -> next cycle pending = 0, w_enb = 0, st_ready = 1.
